alu_issue: RTL

Request-side front end for the 2-stage registered 4-bit ALU. It accepts operations over a valid/ready handshake and drives the ALU's A/B/opcode inputs. It tracks each operation through the ALU's fixed 2-cycle latency, captures `alu_out` into a result FIFO, and returns results in order over a second valid/ready handshake. A credit check keeps results from ever being dropped under downstream backpressure.

---
 rtl/alu_issue.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/alu_issue.sv
// alu_issue -- request-side front end for a 2-stage registered 4-bit ALU.
//
// Accepts operations over a valid/ready handshake, drives the ALU operand and
// opcode inputs from registers, follows each operation through the ALU's fixed
// 2-cycle latency and captures the result into a small result FIFO.
// Results return in acceptance order over a second valid/ready handshake.
// A credit count (in-flight operations plus FIFO occupancy) throttles
// req_ready, so the FIFO can never overflow under downstream backpressure.
//
// Optional feature macro: ALU_ISSUE_CHECK_EN
//   defined   : operands travel with the valid pipeline and a reference model
//               compares every captured alu_out; a mismatch sets sticky err.
//   undefined : no operand pipeline, no comparator, err tied to 0.
//
// Ports
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready     request handshake
//   req_a, req_b, req_op    operands and opcode (00 add, 01 mul, 10 or, 11 and)
//   alu_a, alu_b, alu_opcode registered drive to the ALU
//   alu_rst                 active-high ALU reset (= !rst_n)
//   alu_out                 ALU result (valid 2 edges after alu_* load)
//   rsp_valid/rsp_ready     response handshake
//   rsp_data, rsp_op        result and echoed opcode at the FIFO head
//   err                     sticky result-mismatch flag

module alu_issue #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] req_a,
  input  logic [3:0] req_b,
  input  logic [1:0] req_op,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [1:0] alu_opcode,
  output logic       alu_rst,
  input  logic [7:0] alu_out,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic [1:0] rsp_op,
  output logic       err
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  // wide enough for 3 in-flight operations plus a full FIFO
  localparam int OW = CW + 2;

  logic [3:0]    alu_a_reg;
  logic [3:0]    alu_b_reg;
  logic [1:0]    alu_opcode_reg;
  logic [2:0]    v_reg;
  logic [1:0]    op_pipe_reg [1:2];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;
  logic [9:0]    fifo_mem_reg [FIFO_DEPTH];
  logic [OW-1:0] outstanding;
  logic          accept;
  logic          push;
  logic          pop;

  assign alu_rst = !rst_n;

  // Credit: every accepted operation holds a slot until its result is popped.
  assign outstanding = OW'(v_reg[0]) + OW'(v_reg[1]) + OW'(v_reg[2]) + OW'(count_reg);
  assign req_ready   = (outstanding < OW'(FIFO_DEPTH));

  assign accept    = req_valid && req_ready;
  assign push      = v_reg[2];
  assign rsp_valid = (count_reg != '0);
  assign pop       = rsp_valid && rsp_ready;

  assign alu_a      = alu_a_reg;
  assign alu_b      = alu_b_reg;
  assign alu_opcode = alu_opcode_reg;

  // Issue registers and valid/opcode pipeline. Stage 0 of the opcode pipeline
  // is alu_opcode_reg itself; it holds when nothing is accepted, which is
  // harmless because v_reg[0] is then 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a_reg      <= '0;
      alu_b_reg      <= '0;
      alu_opcode_reg <= '0;
      v_reg          <= '0;
      op_pipe_reg[1] <= '0;
      op_pipe_reg[2] <= '0;
    end else begin
      if (accept) begin
        alu_a_reg      <= req_a;
        alu_b_reg      <= req_b;
        alu_opcode_reg <= req_op;
      end
      v_reg          <= {v_reg[1:0], accept};
      op_pipe_reg[1] <= alu_opcode_reg;
      op_pipe_reg[2] <= op_pipe_reg[1];
    end
  end

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      count_reg <= count_next;
    end
  end

  // Result storage, one register per entry so reset can clear it and the
  // head reads combinationally.
  genvar gi;
  generate
    for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          fifo_mem_reg[gi] <= '0;
        end else if (push && (wr_ptr_reg == PW'(gi))) begin
          fifo_mem_reg[gi] <= {op_pipe_reg[2], alu_out};
        end
      end
    end
  endgenerate

  assign rsp_data = fifo_mem_reg[rd_ptr_reg][7:0];
  assign rsp_op   = fifo_mem_reg[rd_ptr_reg][9:8];

`ifdef ALU_ISSUE_CHECK_EN
  logic [3:0] a_pipe_reg [1:2];
  logic [3:0] b_pipe_reg [1:2];
  logic       err_reg;
  logic [7:0] expected;

  function automatic logic [7:0] ref_result(input logic [3:0] a, input logic [3:0] b,
                                            input logic [1:0] op);
    logic [7:0] r;
    case (op)
      2'b00:   r = {4'b0, a} + {4'b0, b};
      2'b01:   r = {4'b0, a} * {4'b0, b};
      2'b10:   r = {4'b0, a | b};
      default: r = {4'b0, a & b};
    endcase
    return r;
  endfunction

  assign expected = ref_result(a_pipe_reg[2], b_pipe_reg[2], op_pipe_reg[2]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_pipe_reg[1] <= '0;
      a_pipe_reg[2] <= '0;
      b_pipe_reg[1] <= '0;
      b_pipe_reg[2] <= '0;
      err_reg       <= 1'b0;
    end else begin
      a_pipe_reg[1] <= alu_a_reg;
      a_pipe_reg[2] <= a_pipe_reg[1];
      b_pipe_reg[1] <= alu_b_reg;
      b_pipe_reg[2] <= b_pipe_reg[1];
      if (push && (alu_out != expected)) err_reg <= 1'b1;
    end
  end

  assign err = err_reg;
`else
  assign err = 1'b0;
`endif

endmodule
